// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: one micro-step per clock, Moore outputs except the FETCH ir/pc load.
// Latency: 2-5 cycles per instruction plus memory wait cycles; requests hold until i_mem_ready.
module mips_multicycle_ctrl (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_pc_write_cond,
    output logic        o_i_or_d,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_mem_to_reg,
    output logic        o_reg_dst,
    output logic        o_reg_write,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic [1:0]  o_pc_source,
    output logic [3:0]  o_state,
    output logic        o_illegal_op,
    output logic [31:0] o_retired
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_ADDI_EXEC = 4'd8;
    localparam logic [3:0] S_ADDI_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [3:0]  r_state;
    logic        r_illegal_op;
    logic [31:0] r_retired;
    logic [3:0]  w_next;
    logic        w_set_illegal;
    logic        w_retire;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_FETCH;
            r_illegal_op <= 1'b0;
            r_retired    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) r_illegal_op <= 1'b1;
            if (w_retire)      r_retired    <= r_retired + 32'd1;
        end
    end

    // Retirement is counted on the edge that returns to FETCH from a completing state.
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH:     if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next        = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (i_opcode == OP_LW)      w_next = S_MEM_READ;
                else if (i_opcode == OP_SW) w_next = S_MEM_WRITE;
                else                        w_next = S_FETCH;
            end
            S_MEM_READ:  if (i_mem_ready) w_next = S_MEM_WB;
            S_MEM_WRITE: begin
                if (i_mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_EXECUTE:   w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:     w_next = S_FETCH;
        endcase
    end

    // Reset gates every strobe so nothing is issued while it is held.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_pc_source     = 2'b00;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_read  = 1'b1;
                    o_alu_src_b = 2'b01;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                end
                S_DECODE:    o_alu_src_b = 2'b11;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    o_mem_read = 1'b1;
                    o_i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    o_mem_write = 1'b1;
                    o_i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b10;
                end
                S_R_WB: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 1'b1;
                end
                S_ADDI_WB:   o_reg_write = 1'b1;
                S_BRANCH: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_op        = 2'b01;
                    o_pc_write_cond = 1'b1;
                    o_pc_source     = 2'b01;
                end
                S_JUMP: begin
                    o_pc_write  = 1'b1;
                    o_pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_illegal_op = r_illegal_op;
    assign o_retired    = r_retired;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected cycle traces built from the state table,
// driven with random opcodes, random memory wait counts and mid-instruction reset pulses.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] retired;

    mips_multicycle_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond), .o_i_or_d(i_or_d),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_write(ir_write),
        .o_mem_to_reg(mem_to_reg), .o_reg_dst(reg_dst), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_pc_source(pc_source), .o_state(state), .o_illegal_op(illegal_op),
        .o_retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        rdy;
        logic [5:0]  op;
    } row_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ret = 0;
    logic        exp_ill = 0;
    row_t        trace[$];

    logic [15:0] ctrl_obs;
    assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    function automatic logic [15:0] mk(input logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                       input logic [1:0] asb, aop, psrc);
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [15:0] ctrl, input logic rdy,
                        input logic [5:0] op);
        row_t r;
        r.st = st; r.ctrl = ctrl; r.rdy = rdy; r.op = op;
        trace.push_back(r);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
    endfunction

    // Expected per-cycle behaviour of one instruction, straight from the state table.
    task automatic build(input logic [5:0] op, input int fw, input int mw);
        trace.delete();
        for (int i = 0; i < fw; i++)
            push(4'd0, mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00), 1'b0, 6'($urandom));
        push(4'd0, mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00), 1'b1, 6'($urandom));
        push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00), 1'($urandom), op);
        case (op)
            6'h00: begin
                push(4'd6, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00), 1'($urandom), 6'($urandom));
                push(4'd7, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00), 1'($urandom), 6'($urandom));
            end
            6'h08: begin
                push(4'd8, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 1'($urandom), 6'($urandom));
                push(4'd9, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00), 1'($urandom), 6'($urandom));
            end
            6'h23: begin
                push(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 1'($urandom), op);
                for (int i = 0; i <= mw; i++)
                    push(4'd3, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00), 1'(i == mw), 6'($urandom));
                push(4'd4, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00), 1'($urandom), 6'($urandom));
            end
            6'h2B: begin
                push(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00), 1'($urandom), op);
                for (int i = 0; i <= mw; i++)
                    push(4'd5, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00), 1'(i == mw), 6'($urandom));
            end
            6'h04: push(4'd10, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01), 1'($urandom), 6'($urandom));
            6'h02: push(4'd11, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10), 1'($urandom), 6'($urandom));
            default: ;
        endcase
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_ctrl"}, 32'(ctrl_obs), 32'd0);
        check({tag, "_retired"}, retired, 32'd0);
        check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 of the next instruction's first cycle.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic [3:0] abort_st);
        logic aborted = 1'b0;
        build(op, fw, mw);
        for (int i = 0; i < trace.size() && !aborted; i++) begin
            opcode    = trace[i].op;
            mem_ready = trace[i].rdy;
            #1;
            check($sformatf("op%02h_c%0d_state", op, i), 32'(state), 32'(trace[i].st));
            check($sformatf("op%02h_c%0d_ctrl", op, i), 32'(ctrl_obs), 32'(trace[i].ctrl));
            check($sformatf("op%02h_c%0d_retired", op, i), retired, exp_ret);
            check($sformatf("op%02h_c%0d_illegal", op, i), 32'(illegal_op), 32'(exp_ill));
            if (trace[i].st == abort_st) begin
                rst = 1'b1;
                #1;
                reset_checks($sformatf("rst_in_st%0d", abort_st));
                @(posedge clk); #1;
                reset_checks($sformatf("rst_hold_st%0d", abort_st));
                rst = 1'b0;
                exp_ret = 0;
                exp_ill = 1'b0;
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!aborted) begin
            if (is_legal(op)) exp_ret = exp_ret + 1;
            else              exp_ill = 1'b1;
        end
    endtask

    logic [5:0] ops[7];
    logic [5:0] op;

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        #2;
        reset_checks("reset_init");
        @(posedge clk); #1;
        reset_checks("reset_edge");
        rst = 1'b0;

        run_instr(6'h08, 0, 0, 4'hF);
        run_instr(6'h08, 0, 0, 4'hF);
        run_instr(6'h00, 0, 0, 4'hF);
        check("retired_after_3", retired, 32'd3);
        run_instr(6'h23, 0, 3, 4'hF);
        run_instr(6'h2B, 0, 0, 4'hF);
        run_instr(6'h23, 0, 0, 4'hF);
        run_instr(6'h04, 0, 0, 4'hF);
        run_instr(6'h04, 1, 0, 4'hF);
        run_instr(6'h3F, 0, 0, 4'hF);
        run_instr(6'h02, 2, 0, 4'hF);
        check("illegal_sticky", 32'(illegal_op), 32'd1);

        run_instr(6'h08, 0, 0, 4'd9);
        run_instr(6'h3F, 0, 0, 4'hF);
        run_instr(6'h00, 0, 0, 4'hF);
        run_instr(6'h2B, 1, 2, 4'd5);

        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'h3F) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 4'hF);
        end
        check("final_retired", retired, exp_ret);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
